// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
//
// It keeps shadow copies of the EX and MEM destination registers. From them it
// derives the operand-forward selects, load-use stalls, multi-cycle MDU waits,
// memory-wait freezes and branch flushes. These drive the IF/ID and ID/EX
// pipeline registers.
//
// Optional feature: define HAZARD_PERF_EN to build the stall/flush perf
// counters. When it is undefined, both counter ports are tied to 0 and no
// counter flops are built.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      ID holds a real instruction
//   id_rs1/id_rs2, *_used         ID source indices and read enables
//   id_rd, id_wen                 ID destination index and write enable
//   id_is_load, id_is_mdu         ID instruction class
//   ex_redirect                   mispredict resolved in EX
//   mdu_done                      MDU result valid (pulse)
//   mem_wait                      data memory not ready
//   fwd_rs1_sel/fwd_rs2_sel       00 regfile, 01 from EX, 10 from MEM
//   stall_if, stall_id            hold PC and IF/ID
//   bubble_ex, freeze_ex          load NOP into / hold ID/EX
//   flush_id                      squash IF/ID
//   mdu_start                     registered one-cycle MDU launch pulse
//   perf_stall_cnt/perf_flush_cnt perf counters
module hazard_ctrl #(
    parameter int unsigned REG_ID_W = 5,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_ID_W-1:0] id_rs1,
    input  logic [REG_ID_W-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_wen,
    input  logic                id_is_load,
    input  logic                id_is_mdu,
    input  logic                ex_redirect,
    input  logic                mdu_done,
    input  logic                mem_wait,
    output logic [1:0]          fwd_rs1_sel,
    output logic [1:0]          fwd_rs2_sel,
    output logic                stall_if,
    output logic                stall_id,
    output logic                bubble_ex,
    output logic                freeze_ex,
    output logic                flush_id,
    output logic                mdu_start,
    output logic [PERF_W-1:0]   perf_stall_cnt,
    output logic [PERF_W-1:0]   perf_flush_cnt
);

    typedef enum logic [0:0] {StRun, StMduWait} state_e;

    state_e              state_q;
    logic                mdu_start_q;

    // Only the shadow fields that affect a decision are stored. The EX is_mdu
    // bit and the MEM is_load bit never change an output.
    logic                ex_valid_q, ex_wen_q, ex_is_load_q;
    logic [REG_ID_W-1:0] ex_rd_q;
    logic                mem_valid_q, mem_wen_q;
    logic [REG_ID_W-1:0] mem_rd_q;

    logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
    logic load_use;
    logic [1:0] fwd1_c, fwd2_c;
    logic sif_c, sid_c, bex_c, fex_c, fid_c, launch_c;

    // x0 never hits: the index is checked for nonzero first.
    assign rs1_ex_hit  = (id_rs1 != '0) && id_rs1_used && ex_valid_q && ex_wen_q
                         && (ex_rd_q == id_rs1);
    assign rs2_ex_hit  = (id_rs2 != '0) && id_rs2_used && ex_valid_q && ex_wen_q
                         && (ex_rd_q == id_rs2);
    assign rs1_mem_hit = (id_rs1 != '0) && id_rs1_used && mem_valid_q && mem_wen_q
                         && (mem_rd_q == id_rs1);
    assign rs2_mem_hit = (id_rs2 != '0) && id_rs2_used && mem_valid_q && mem_wen_q
                         && (mem_rd_q == id_rs2);

    assign load_use = id_valid && ex_is_load_q && (rs1_ex_hit || rs2_ex_hit);

    // An EX hit on a load does not forward from EX. That case stalls instead.
    always_comb begin
        fwd1_c = 2'b00;
        if (rs1_ex_hit && !ex_is_load_q) fwd1_c = 2'b01;
        else if (rs1_mem_hit)            fwd1_c = 2'b10;
        fwd2_c = 2'b00;
        if (rs2_ex_hit && !ex_is_load_q) fwd2_c = 2'b01;
        else if (rs2_mem_hit)            fwd2_c = 2'b10;
    end

    // Priority in RUN: mem_wait > redirect > load-use > normal advance.
    always_comb begin
        sif_c    = 1'b0;
        sid_c    = 1'b0;
        bex_c    = 1'b0;
        fex_c    = 1'b0;
        fid_c    = 1'b0;
        launch_c = 1'b0;
        case (state_q)
            StRun: begin
                if (mem_wait) begin
                    sif_c = 1'b1;
                    sid_c = 1'b1;
                    fex_c = 1'b1;
                end else if (ex_redirect) begin
                    fid_c = 1'b1;
                    bex_c = 1'b1;
                end else if (load_use) begin
                    sif_c = 1'b1;
                    sid_c = 1'b1;
                    bex_c = 1'b1;
                end else begin
                    launch_c = id_valid && id_is_mdu;
                end
            end
            default: begin
                sif_c = 1'b1;
                sid_c = 1'b1;
                fex_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            mdu_start_q  <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_wen_q     <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rd_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_rd_q     <= '0;
        end else begin
            mdu_start_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (!mem_wait) begin
                        mem_valid_q <= ex_valid_q;
                        mem_wen_q   <= ex_wen_q;
                        mem_rd_q    <= ex_rd_q;
                        if (bex_c) begin
                            ex_valid_q <= 1'b0;
                        end else begin
                            ex_valid_q   <= id_valid;
                            ex_wen_q     <= id_wen;
                            ex_is_load_q <= id_is_load;
                            ex_rd_q      <= id_rd;
                            if (launch_c) begin
                                state_q     <= StMduWait;
                                mdu_start_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // EX holds the MDU op while a bubble drains MEM.
                    mem_valid_q <= 1'b0;
                    if (mdu_done && !mem_wait) state_q <= StRun;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held.
    assign fwd_rs1_sel = rst ? 2'b00 : fwd1_c;
    assign fwd_rs2_sel = rst ? 2'b00 : fwd2_c;
    assign stall_if    = !rst && sif_c;
    assign stall_id    = !rst && sid_c;
    assign bubble_ex   = !rst && bex_c;
    assign freeze_ex   = !rst && fex_c;
    assign flush_id    = !rst && fid_c;
    assign mdu_start   = !rst && mdu_start_q;

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] PerfOne = 1;

    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (sid_c) stall_cnt_q <= stall_cnt_q + PerfOne;
            if (fid_c) flush_cnt_q <= flush_cnt_q + PerfOne;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Stimulus pushes the expected output vector
// for each cycle. A monitor on the falling edge pops and compares the vector.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_wen, id_is_load, id_is_mdu;
    logic       ex_redirect, mdu_done, mem_wait;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic       stall_if, stall_id, bubble_ex, freeze_ex, flush_id, mdu_start;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    // Control bits are ordered {stall_if, stall_id, bubble_ex, freeze_ex, flush_id, mdu_start}.
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b111000;
    localparam logic [5:0] C_FRZ   = 6'b110100;
    localparam logic [5:0] C_RDR   = 6'b001010;
    localparam logic [5:0] C_MDUST = 6'b110101;

    typedef struct {
        string      name;
        logic       rst;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    hazard_ctrl #(.REG_ID_W(5), .PERF_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_wen         (id_wen),
        .id_is_load     (id_is_load),
        .id_is_mdu      (id_is_mdu),
        .ex_redirect    (ex_redirect),
        .mdu_done       (mdu_done),
        .mem_wait       (mem_wait),
        .fwd_rs1_sel    (fwd_rs1_sel),
        .fwd_rs2_sel    (fwd_rs2_sel),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .bubble_ex      (bubble_ex),
        .freeze_ex      (freeze_ex),
        .flush_id       (flush_id),
        .mdu_start      (mdu_start),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic wen, input logic ld, input logic mdu);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = rd;
        id_wen      = wen;
        id_is_load  = ld;
        id_is_mdu   = mdu;
    endtask

    task automatic push(input string name, input logic [1:0] f1, input logic [1:0] f2,
                        input logic [5:0] ctl, input logic r = 1'b0);
        exp_t e;
        e.name = name;
        e.rst  = r;
        e.v    = {f1, f2, ctl};
        sb.push_back(e);
    endtask

    // Monitor: compare each cycle's outputs on the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [9:0] act;
            logic [31:0] want_s, want_f;
            e   = sb.pop_front();
            act = {fwd_rs1_sel, fwd_rs2_sel, stall_if, stall_id, bubble_ex, freeze_ex,
                   flush_id, mdu_start};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s: got %b want %b", e.name, act, e.v);
            end
            if (e.rst) begin
                m_stall = 0;
                m_flush = 0;
            end
`ifdef HAZARD_PERF_EN
            want_s = m_stall;
            want_f = m_flush;
`else
            want_s = 32'd0;
            want_f = 32'd0;
`endif
            checks++;
            if (perf_stall_cnt !== want_s || perf_flush_cnt !== want_f) begin
                failures++;
                $display("FAIL %s_perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         e.name, perf_stall_cnt, perf_flush_cnt, want_s, want_f);
            end
            if (e.v[4]) m_stall++;
            if (e.v[1]) m_flush++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ex_redirect = 1'b0;
        mdu_done = 1'b0;
        mem_wait = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset: outputs are masked even with mem_wait high.
        next(); push("reset", 2'b00, 2'b00, C_NONE, 1'b1);

        // 1. Forwarding from EX and from MEM.
        next(); rst = 1'b0; mem_wait = 1'b0;
        set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);  push("t1_add_x5", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 5, 5, 1, 1, 6, 1, 0, 0);  push("t1_fwd_ex", 2'b01, 2'b01, C_NONE);
        next(); set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);  push("t1_add_x5_b", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 3, 4, 1, 1, 12, 1, 0, 0); push("t1_indep", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 5, 5, 1, 1, 6, 1, 0, 0);  push("t1_fwd_mem", 2'b10, 2'b10, C_NONE);
        next(); set_id(1, 6, 6, 1, 0, 13, 1, 0, 0); push("t1_rs2_unused", 2'b01, 2'b00, C_NONE);

        // 2. Load-use, then the same pattern through x0.
        next(); set_id(1, 1, 0, 1, 0, 7, 1, 1, 0);  push("t2_lw_x7", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 7, 0, 1, 1, 8, 1, 0, 0);  push("t2_load_use", 2'b00, 2'b00, C_LU);
        next(); push("t2_after_stall", 2'b10, 2'b00, C_NONE);
        next(); set_id(1, 1, 0, 1, 0, 0, 1, 1, 0);  push("t2_lw_x0", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 0, 0, 1, 1, 8, 1, 0, 0);  push("t2_x0_no_stall", 2'b00, 2'b00, C_NONE);

        // 3. MDU launch, wait, done, dependent forward.
        next(); set_id(1, 1, 2, 1, 1, 9, 1, 0, 1);  push("t3_mul_id", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 9, 0, 1, 1, 10, 1, 0, 0); push("t3_mdu_start", 2'b01, 2'b00, C_MDUST);
        for (int i = 0; i < 4; i++) begin
            next(); push("t3_mdu_wait", 2'b01, 2'b00, C_FRZ);
        end
        next(); mdu_done = 1'b1; push("t3_mdu_done", 2'b01, 2'b00, C_FRZ);
        next(); mdu_done = 1'b0; push("t3_dep_fwd_ex", 2'b01, 2'b00, C_NONE);

        // 4. Redirect together with a load-use match.
        next(); set_id(1, 1, 0, 1, 0, 14, 1, 1, 0); push("t4_lw_x14", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 14, 0, 1, 1, 15, 1, 0, 0); ex_redirect = 1'b1;
        push("t4_redirect_wins", 2'b00, 2'b00, C_RDR);
        next(); ex_redirect = 1'b0; push("t4_no_extra_stall", 2'b10, 2'b00, C_NONE);

        // 5. mem_wait during a load-use.
        next(); set_id(1, 1, 0, 1, 0, 16, 1, 1, 0); push("t5_lw_x16", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 16, 0, 1, 1, 17, 1, 0, 0); mem_wait = 1'b1;
        push("t5_freeze", 2'b00, 2'b00, C_FRZ);
        next(); push("t5_freeze", 2'b00, 2'b00, C_FRZ);
        next(); push("t5_freeze", 2'b00, 2'b00, C_FRZ);
        next(); mem_wait = 1'b0; push("t5_load_use", 2'b00, 2'b00, C_LU);
        next(); push("t5_fwd_mem", 2'b10, 2'b00, C_NONE);

        // 6. Reset in the middle of MDU_WAIT.
        next(); set_id(1, 1, 0, 1, 0, 18, 1, 0, 1); push("t6_div_id", 2'b00, 2'b00, C_NONE);
        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);  push("t6_mdu_start", 2'b00, 2'b00, C_MDUST);
        next(); push("t6_mdu_wait", 2'b00, 2'b00, C_FRZ);
        next(); rst = 1'b1; push("t6_reset_mid_wait", 2'b00, 2'b00, C_NONE, 1'b1);
        next(); push("t6_reset_held", 2'b00, 2'b00, C_NONE, 1'b1);
        next(); rst = 1'b0; push("t6_run_after_reset", 2'b00, 2'b00, C_NONE);
        next(); set_id(1, 18, 0, 1, 1, 19, 1, 0, 0); push("t6_shadow_cleared", 2'b00, 2'b00, C_NONE);
        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);   push("t6_idle", 2'b00, 2'b00, C_NONE);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
